// File: rtl/beta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beta_pkg
//  Description : Shared definitions for the memory-mapped bus timer:
//                register offsets, CTRL/STATUS bit positions, reset values,
//                prescaler width and the timer state enumeration.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package beta_pkg;

   // Word offsets within the 16-byte register window (memAddr[3:2])
   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_COUNT   = 2'd1;
   localparam logic [1:0] OFF_COMPARE = 2'd2;
   localparam logic [1:0] OFF_STATUS  = 2'd3;

   // CTRL bit indices
   localparam int CTRL_EN   = 0;
   localparam int CTRL_IE   = 1;
   localparam int CTRL_AUTO = 2;

   // STATUS bit indices
   localparam int STATUS_MATCH = 0;

   // Prescaler counter width; covers PRESCALE values 1..65535
   localparam int PRESCALE_W = 16;

   // Register reset values
   localparam logic [31:0] COUNT_RST   = 32'h0000_0000;
   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

   typedef enum logic [0:0] {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } timer_state_t;

   // Read-back image of CTRL; unused bits return zero
   function automatic logic [31:0] pack_ctrl(input logic en,
                                             input logic ie,
                                             input logic auto_reload);
      pack_ctrl = {29'd0, auto_reload, ie, en};
   endfunction

endpackage : beta_pkg
`default_nettype wire

// File: rtl/bus_timer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Count-tick generator for bus_timer. With TIMER_PRESCALE_EN
//                defined, emits a one-cycle tick every PRESCALE cycles while
//                run is high, the first one PRESCALE cycles after run rises;
//                the divider is held at zero while run is low. Without the
//                macro, no divider flops exist and tick simply follows run.
//  Macro       : TIMER_PRESCALE_EN
//  Ports       : clk   in  1  clock, rising edge
//                reset in  1  asynchronous active-high reset
//                run   in  1  timer is in the RUNNING state
//                tick  out 1  count enable for this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module tick_gen
   import beta_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

`ifdef TIMER_PRESCALE_EN
   localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

   logic [PRESCALE_W-1:0] div_count;
   logic                  at_last;

   assign at_last = (div_count == LAST);

   // Divider restarts from zero whenever the timer is not running, so a
   // fresh RUNNING period always waits a full PRESCALE cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_count <= '0;
      end else if (!run || at_last) begin
         div_count <= '0;
      end else begin
         div_count <= div_count + 1'b1;
      end
   end

   assign tick = run && at_last;
`else
   // Divider disabled: every RUNNING cycle is a tick.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, clk, reset, PRESCALE_W'(PRESCALE)};

   assign tick = run;
`endif

endmodule : tick_gen
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer
//  Description : Memory-mapped 32-bit timer for a simple CPU data port.
//                Four word registers at BASE_ADDR: CTRL {AUTO,IE,EN},
//                COUNT, COMPARE, STATUS {MATCH (write-1-to-clear)}.
//                On each tick COUNT advances; a tick with COUNT==COMPARE
//                sets MATCH and either reloads COUNT to zero (AUTO) or
//                steps COUNT once more and stops the timer (one-shot).
//  Macro       : TIMER_PRESCALE_EN  enables the PRESCALE tick divider;
//                when undefined the timer ticks every running cycle.
//  Ports       : clk          in  1   clock, rising edge
//                reset        in  1   asynchronous active-high reset
//                memAddr      in  32  byte address
//                memWriteData in  32  store data
//                MemRead      in  1   load strobe
//                MemWrite     in  1   store strobe
//                memReadData  out 32  load data (combinational)
//                irq          out 1   MATCH & IE
//  Revision    : 1.0  initial release
// ============================================================================
module bus_timer
   import beta_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
   parameter int unsigned PRESCALE  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAddr,
   input  logic [31:0] memWriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] memReadData,
   output logic        irq
);

   // ------------------------------------------------------------------
   // Architectural state and next-state values
   // ------------------------------------------------------------------
   timer_state_t state;
   timer_state_t state_next;

   logic        en;
   logic        ie;
   logic        auto_reload;
   logic [31:0] count;
   logic [31:0] compare;
   logic        match;

   logic        en_next;
   logic        ie_next;
   logic        auto_next;
   logic [31:0] count_next;
   logic [31:0] compare_next;
   logic        match_next;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic       hit;
   logic [1:0] offset;
   logic       wr_hit;
   logic       wr_ctrl;
   logic       wr_count;
   logic       wr_compare;
   logic       wr_status;

   assign hit        = (memAddr[31:4] == BASE_ADDR[31:4]);
   assign offset     = memAddr[3:2];
   assign wr_hit     = MemWrite && hit;
   assign wr_ctrl    = wr_hit && (offset == OFF_CTRL);
   assign wr_count   = wr_hit && (offset == OFF_COUNT);
   assign wr_compare = wr_hit && (offset == OFF_COMPARE);
   assign wr_status  = wr_hit && (offset == OFF_STATUS);

   // Byte lane bits play no part in decode.
   logic unused_addr;
   assign unused_addr = &{1'b0, memAddr[1:0]};

   // ------------------------------------------------------------------
   // Tick generation
   // ------------------------------------------------------------------
   logic run;
   logic tick;
   logic match_hit;

   assign run = (state == RUNNING);

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .tick  (tick)
   );

   // Compare uses the registered COUNT/COMPARE, i.e. the values the CPU
   // would read back in this same cycle.
   assign match_hit = tick && (count == compare);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= STOPPED;
         en          <= 1'b0;
         ie          <= 1'b0;
         auto_reload <= 1'b0;
         count       <= COUNT_RST;
         compare     <= COMPARE_RST;
         match       <= 1'b0;
      end else begin
         state       <= state_next;
         en          <= en_next;
         ie          <= ie_next;
         auto_reload <= auto_next;
         count       <= count_next;
         compare     <= compare_next;
         match       <= match_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Later assignments take priority over earlier ones:
   //   - a CPU write to COUNT overrides the tick increment / reload
   //   - a CPU write to CTRL overrides the one-shot EN clear
   //   - a match set overrides a same-cycle MATCH clear
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state;
      en_next      = en;
      ie_next      = ie;
      auto_next    = auto_reload;
      count_next   = count;
      compare_next = compare;
      match_next   = match;

      // Counting
      if (tick) begin
         if (match_hit && auto_reload) begin
            count_next = '0;
         end else begin
            count_next = count + 32'd1;
         end
      end

      // One-shot completion drops EN
      if (match_hit && !auto_reload) begin
         en_next = 1'b0;
      end

      // CPU writes
      if (wr_ctrl) begin
         en_next   = memWriteData[CTRL_EN];
         ie_next   = memWriteData[CTRL_IE];
         auto_next = memWriteData[CTRL_AUTO];
      end
      if (wr_count) begin
         count_next = memWriteData;
      end
      if (wr_compare) begin
         compare_next = memWriteData;
      end
      if (wr_status && memWriteData[STATUS_MATCH]) begin
         match_next = 1'b0;
      end

      if (match_hit) begin
         match_next = 1'b1;
      end

      // Run/stop sequencing; stays in step with the EN bit
      case (state)
         STOPPED: begin
            if (wr_ctrl && memWriteData[CTRL_EN]) begin
               state_next = RUNNING;
            end
         end
         RUNNING: begin
            if (wr_ctrl) begin
               state_next = memWriteData[CTRL_EN] ? RUNNING : STOPPED;
            end else if (match_hit && !auto_reload) begin
               state_next = STOPPED;
            end
         end
         default: begin
            state_next = STOPPED;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Read mux: combinational, returns current (pre-write) register values
   // ------------------------------------------------------------------
   always_comb begin
      memReadData = '0;
      if (MemRead && hit) begin
         case (offset)
            OFF_CTRL:    memReadData = pack_ctrl(en, ie, auto_reload);
            OFF_COUNT:   memReadData = count;
            OFF_COMPARE: memReadData = compare;
            OFF_STATUS:  memReadData = {31'd0, match};
            default:     memReadData = '0;
         endcase
      end
   end

   // Interrupt comes straight from flops; no path from the bus inputs.
   assign irq = match & ie;

endmodule : bus_timer
`default_nettype wire

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, 16-byte-aligned base of the register window.
REQ-002 SHALL have parameter PRESCALE, default 4, clock cycles per count tick (range 1..65535).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port memAddr, input, 32, byte address from the CPU data port.
REQ-006 SHALL have port memWriteData, input, 32, store data.
REQ-007 SHALL have port MemRead, input, 1, load strobe.
REQ-008 SHALL have port MemWrite, input, 1, store strobe.
REQ-009 SHALL have port memReadData, output, 32, load data.
REQ-010 SHALL have port irq, output, 1, interrupt request to the CPU.

Function
REQ-011 SHALL decode a hit when memAddr[31:4]==BASE_ADDR[31:4]; offset = memAddr[3:2]; memAddr[1:0] ignored.
REQ-012 SHALL map: 0 CTRL {EN bit0, IE bit1, AUTO bit2}, 1 COUNT, 2 COMPARE, 3 STATUS {MATCH bit0}.
REQ-013 SHALL return read data combinationally in the same cycle as MemRead and hit; otherwise memReadData = 0.
REQ-014 SHALL commit writes at the clock edge when MemWrite and hit; unused CTRL/STATUS bits read 0.
REQ-015 SHALL treat STATUS writes as write-1-to-clear on MATCH.
REQ-016 SHALL implement states STOPPED and RUNNING; STOPPED->RUNNING when EN written 1, RUNNING->STOPPED when EN written 0 or on a one-shot match.
REQ-017 SHALL, in RUNNING, assert one tick every PRESCALE cycles, first tick PRESCALE cycles after entering RUNNING; prescaler clears in STOPPED.
REQ-018 SHALL, on tick with COUNT==COMPARE: set MATCH; if AUTO, COUNT<=0 and stay RUNNING; else COUNT<=COUNT+1, EN<=0, go STOPPED.
REQ-019 SHALL, on tick without match, COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF->0.
REQ-020 SHALL drive irq = MATCH & IE, from flops only, no combinational path from bus inputs.
REQ-021 SHALL give a CPU write to COUNT priority over a same-cycle tick increment or reload.
REQ-022 SHALL give a same-cycle match set priority over a STATUS W1C clear.
REQ-023 SHALL, when MemRead and MemWrite are both high, perform the write and return the pre-write value.

Reset
REQ-024 SHALL, on reset, force CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, prescaler=0, state STOPPED, irq=0, regardless of clk.
REQ-025 SHALL abandon any in-progress prescale period on reset.

Configuration
REQ-026 SHALL, with TIMER_PRESCALE_EN defined, use the PRESCALE divider per REQ-017.
REQ-027 SHALL, without TIMER_PRESCALE_EN, tick every cycle in RUNNING, ignore PRESCALE, and omit prescaler flops.

Structure
REQ-028 SHALL place register offsets, CTRL bit indices and the state enum in shared package beta_pkg.
REQ-029 SHALL implement the prescaler as sub-module tick_gen (inputs clk, reset, run; output tick).

Verification
REQ-030 Reset mid-run: COUNT=5, RUNNING, reset pulse between edges -> all registers at reset values immediately, irq=0.
REQ-031 One-shot: COMPARE=3, write CTRL=3 (EN, IE), PRESCALE=4 -> MATCH and irq at tick 4 (cycle 16), COUNT=4, CTRL reads 2.
REQ-032 Auto-reload: COMPARE=2, CTRL=5 -> COUNT sequence 0,1,2,0,1,2; MATCH set, irq stays 0 with IE=0.
REQ-033 W1C race: write STATUS=1 on a matching tick cycle -> MATCH remains 1; write STATUS=1 one cycle later -> MATCH 0, irq 0.
REQ-034 Wrap and collision: COUNT=32'hFFFF_FFFF running, COMPARE=7 -> next tick COUNT=0; a COUNT write of 9 on a tick cycle -> COUNT=9.
REQ-035 Decode: read BASE_ADDR+32'h10 or with MemRead=0 -> memReadData=0; write there -> no register changes.
